// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the W pipeline-register layout used by the writeback stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } wb_state_e;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    valid: 1'b0, stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
    rA: REG_NONE, rB: REG_NONE, valE: 64'd0, valM: 64'd0
  };

endpackage

// File: rtl/wb_dst_decode.sv
// Combinational destination-register decode for the W stage (E port and M port).
module wb_dst_decode
  import y86_pkg::*;
#(
  parameter logic [3:0] SP_REG = REG_RSP
) (
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    unique case (icode)
      I_CMOVXX:               dst_e = cnd ? rB : REG_NONE;
      I_IRMOVQ, I_OPQ:        dst_e = rB;
      I_MRMOVQ:               dst_m = rA;
      I_CALL, I_RET, I_PUSHQ: dst_e = SP_REG;
      I_POPQ: begin
        dst_e = SP_REG;
        dst_m = rA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 W stage: W pipeline register, register-file write ports, status tracking,
// retired-instruction counter and the halt state machine.
module writeback_stage
  import y86_pkg::*;
#(
  parameter int         CNT_W  = 32,
  parameter logic [3:0] SP_REG = REG_RSP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [3:0]       m_rA,
  input  logic [3:0]       m_rB,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  input  logic             w_stall,
  input  logic             w_bubble,
  output logic             we_e,
  output logic [3:0]       dst_e,
  output logic [63:0]      wdata_e,
  output logic             we_m,
  output logic [3:0]       dst_m,
  output logic [63:0]      wdata_m,
  output logic             halted,
  output logic [2:0]       w_stat,
  output logic [CNT_W-1:0] retired
);

  wb_state_e        state_q, state_d;
  w_reg_t           w_q, w_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic run;
  logic w_ok;
  logic w_fault;

  assign run     = (state_q == ST_RUN);
  assign w_ok    = w_q.valid && (w_q.stat == STAT_AOK);
  assign w_fault = w_q.valid && (w_q.stat != STAT_AOK);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    retired_d = retired_q;
    if (run) begin
      if (w_ok && !w_stall) retired_d = retired_q + CNT_W'(1);
      // A faulting instruction freezes W in place so w_stat keeps reporting its status.
      if (w_fault) begin
        state_d = ST_HALTED;
      end else if (w_stall) begin
        w_d = w_q;
      end else if (w_bubble) begin
        w_d = W_BUBBLE;
      end else begin
        w_d = '{valid: m_valid, stat: m_stat, icode: m_icode, cnd: m_cnd,
                rA: m_rA, rB: m_rB, valE: m_valE, valM: m_valM};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      w_q       <= W_BUBBLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      retired_q <= retired_d;
    end
  end

  wb_dst_decode #(
    .SP_REG(SP_REG)
  ) u_dst_decode (
    .icode(w_q.icode),
    .cnd  (w_q.cnd),
    .rA   (w_q.rA),
    .rB   (w_q.rB),
    .dst_e(dst_e),
    .dst_m(dst_m)
  );

  // popq %rsp targets the same register on both ports; the loaded value must win.
  assign we_m    = run && w_ok && (dst_m != REG_NONE);
  assign we_e    = run && w_ok && (dst_e != REG_NONE) && (dst_e != dst_m);
  assign wdata_e = w_q.valE;
  assign wdata_m = w_q.valM;
  assign halted  = !run;
  assign w_stat  = w_q.stat;
  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; a 4-bit counter makes the wrap reachable.
module tb_writeback_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_valid;
  logic [2:0]       m_stat;
  logic [3:0]       m_icode;
  logic             m_cnd;
  logic [3:0]       m_rA;
  logic [3:0]       m_rB;
  logic [63:0]      m_valE;
  logic [63:0]      m_valM;
  logic             w_stall;
  logic             w_bubble;
  logic             we_e;
  logic [3:0]       dst_e;
  logic [63:0]      wdata_e;
  logic             we_m;
  logic [3:0]       dst_m;
  logic [63:0]      wdata_m;
  logic             halted;
  logic [2:0]       w_stat;
  logic [CNT_W-1:0] retired;

  int tests_run = 0;
  int tests_failed = 0;

  writeback_stage #(.CNT_W(CNT_W), .SP_REG(4'h4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode), .m_cnd(m_cnd),
    .m_rA(m_rA), .m_rB(m_rB), .m_valE(m_valE), .m_valM(m_valM),
    .w_stall(w_stall), .w_bubble(w_bubble),
    .we_e(we_e), .dst_e(dst_e), .wdata_e(wdata_e),
    .we_m(we_m), .dst_m(dst_m), .wdata_m(wdata_m),
    .halted(halted), .w_stat(w_stat), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic c, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm);
    m_valid = v; m_stat = st; m_icode = ic; m_cnd = c;
    m_rA = ra; m_rB = rb; m_valE = ve; m_valM = vm;
  endtask

  task automatic drive_bubble();
    drive(1'b0, 3'd1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    w_stall = 0; w_bubble = 0;
    drive_bubble();
    rst_n = 1'b0;
    #12;
    tests_run++; if (we_e !== 1'b0) begin tests_failed++; $display("FAIL reset_we_e got %0b exp 0", we_e); end
    tests_run++; if (we_m !== 1'b0) begin tests_failed++; $display("FAIL reset_we_m got %0b exp 0", we_m); end
    tests_run++; if (dst_e !== 4'hF || dst_m !== 4'hF) begin tests_failed++; $display("FAIL reset_dst got %h/%h exp f/f", dst_e, dst_m); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %0b exp 0", halted); end
    tests_run++; if (retired !== 4'd0) begin tests_failed++; $display("FAIL reset_retired got %0d exp 0", retired); end
    tests_run++; if (w_stat !== 3'd1) begin tests_failed++; $display("FAIL reset_w_stat got %0d exp 1", w_stat); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_irmovq();
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h2, 64'h1234, 64'h0);
    tick();
    tests_run++; if (we_e !== 1'b1 || dst_e !== 4'h2 || wdata_e !== 64'h1234) begin
      tests_failed++; $display("FAIL irmovq_e got we=%0b dst=%h data=%h exp 1/2/1234", we_e, dst_e, wdata_e); end
    tests_run++; if (we_m !== 1'b0) begin tests_failed++; $display("FAIL irmovq_we_m got %0b exp 0", we_m); end
    drive_bubble();
    tick();
    tests_run++; if (retired !== 4'd1) begin tests_failed++; $display("FAIL irmovq_retired got %0d exp 1", retired); end
    tests_run++; if (we_e !== 1'b0) begin tests_failed++; $display("FAIL bubble_we_e got %0b exp 0", we_e); end
  endtask

  task automatic test_popq();
    drive(1, 3'd1, 4'hB, 0, 4'h3, 4'hF, 64'h1008, 64'hAA);
    tick();
    tests_run++; if (we_e !== 1'b1 || dst_e !== 4'h4) begin
      tests_failed++; $display("FAIL popq_e got we=%0b dst=%h exp 1/4", we_e, dst_e); end
    tests_run++; if (we_m !== 1'b1 || dst_m !== 4'h3 || wdata_m !== 64'hAA) begin
      tests_failed++; $display("FAIL popq_m got we=%0b dst=%h data=%h exp 1/3/aa", we_m, dst_m, wdata_m); end
    drive(1, 3'd1, 4'hB, 0, 4'h4, 4'hF, 64'h1010, 64'hBB);
    tick();
    tests_run++; if (we_e !== 1'b0 || we_m !== 1'b1 || dst_m !== 4'h4) begin
      tests_failed++; $display("FAIL popq_rsp got we_e=%0b we_m=%0b dst_m=%h exp 0/1/4", we_e, we_m, dst_m); end
    drive_bubble();
    tick();
    tests_run++; if (retired !== 4'd3) begin tests_failed++; $display("FAIL popq_retired got %0d exp 3", retired); end
  endtask

  task automatic test_cmov();
    drive(1, 3'd1, 4'h2, 0, 4'h1, 4'h5, 64'h77, 64'h0);
    tick();
    tests_run++; if (we_e !== 1'b0 || dst_e !== 4'hF) begin
      tests_failed++; $display("FAIL cmov_nc got we=%0b dst=%h exp 0/f", we_e, dst_e); end
    drive(1, 3'd1, 4'h2, 1, 4'h1, 4'h5, 64'h78, 64'h0);
    tick();
    tests_run++; if (we_e !== 1'b1 || dst_e !== 4'h5) begin
      tests_failed++; $display("FAIL cmov_c got we=%0b dst=%h exp 1/5", we_e, dst_e); end
    tests_run++; if (retired !== 4'd4) begin tests_failed++; $display("FAIL cmov_nc_retired got %0d exp 4", retired); end
    drive_bubble();
    tick();
    tests_run++; if (retired !== 4'd5) begin tests_failed++; $display("FAIL cmov_retired got %0d exp 5", retired); end
  endtask

  task automatic test_stall();
    drive(1, 3'd1, 4'h6, 0, 4'h3, 4'h1, 64'h55, 64'h0);
    tick();
    tests_run++; if (we_e !== 1'b1 || dst_e !== 4'h1) begin
      tests_failed++; $display("FAIL stall_c0 got we=%0b dst=%h exp 1/1", we_e, dst_e); end
    w_stall = 1;
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h7, 64'h99, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (we_e !== 1'b1 || dst_e !== 4'h1 || wdata_e !== 64'h55 || retired !== 4'd5) begin
        tests_failed++; $display("FAIL stall_hold%0d got we=%0b dst=%h data=%h ret=%0d exp 1/1/55/5", i, we_e, dst_e, wdata_e, retired); end
    end
    w_stall = 0;
    drive_bubble();
    tick();
    tests_run++; if (retired !== 4'd6 || we_e !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release got ret=%0d we=%0b exp 6/0", retired, we_e); end
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h7, 64'h77, 64'h0);
    tick();
    w_stall = 1; w_bubble = 1;
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h9, 64'h33, 64'h0);
    tick();
    tests_run++; if (dst_e !== 4'h7 || wdata_e !== 64'h77 || retired !== 4'd6) begin
      tests_failed++; $display("FAIL stall_bubble got dst=%h data=%h ret=%0d exp 7/77/6", dst_e, wdata_e, retired); end
    w_stall = 0;
    tick();
    tests_run++; if (we_e !== 1'b0 || w_stat !== 3'd1 || retired !== 4'd7) begin
      tests_failed++; $display("FAIL bubble_load got we=%0b stat=%0d ret=%0d exp 0/1/7", we_e, w_stat, retired); end
    w_bubble = 0;
  endtask

  task automatic test_halt();
    drive(1, 3'd3, 4'h3, 0, 4'hF, 4'h2, 64'h1, 64'h0);
    tick();
    tests_run++; if (we_e !== 1'b0 || w_stat !== 3'd3 || halted !== 1'b0) begin
      tests_failed++; $display("FAIL adr_w got we=%0b stat=%0d halted=%0b exp 0/3/0", we_e, w_stat, halted); end
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h2, 64'h2, 64'h0);
    tick();
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_enter got %0b exp 1", halted); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (we_e !== 1'b0 || we_m !== 1'b0 || retired !== 4'd7 || w_stat !== 3'd3) begin
        tests_failed++; $display("FAIL halt_frozen%0d got we=%0b/%0b ret=%0d stat=%0d exp 0/0/7/3", i, we_e, we_m, retired, w_stat); end
    end
    apply_reset();
    tests_run++; if (halted !== 1'b0 || retired !== 4'd0 || w_stat !== 3'd1) begin
      tests_failed++; $display("FAIL halt_reset got halted=%0b ret=%0d stat=%0d exp 0/0/1", halted, retired, w_stat); end
  endtask

  task automatic test_async_reset();
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h6, 64'hABC, 64'h0);
    tick();
    drive_bubble();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (we_e !== 1'b0 || dst_e !== 4'hF) begin
      tests_failed++; $display("FAIL async_reset got we=%0b dst=%h exp 0/f", we_e, dst_e); end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    tick();
    drive(1, 3'd1, 4'h3, 0, 4'hF, 4'h2, 64'h5, 64'h0);
    for (int i = 0; i < 16; i++) tick();
    tests_run++; if (retired !== 4'd15) begin tests_failed++; $display("FAIL wrap_max got %0d exp 15", retired); end
    tick();
    tests_run++; if (retired !== 4'd0) begin tests_failed++; $display("FAIL wrap_zero got %0d exp 0", retired); end
    drive_bubble();
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_popq();
    test_cmov();
    test_stall();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
